// File: rtl/vec_alu_pkg.sv
// vec_alu_pkg: sequencer state encoding, ALU select codes and lane slice helper.
package vec_alu_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  function automatic int lane_lo(int i, int w);
    return i * w;
  endfunction
endpackage

// File: rtl/vec_res_fifo.sv
// vec_res_fifo: synchronous result FIFO with occupancy count; reads as zero when empty.
module vec_res_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= wdata;
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign rdata = count != '0 ? mem[rd] : '0;
endmodule

// File: rtl/vec_alu_sequencer.sv
// vec_alu_sequencer: command-driven vector ALU initiator with credit-based result FIFO.
// Optional VEC_SEQ_INF_COUNT_EN adds a saturating per-command inf lane counter.
module vec_alu_sequencer
  import vec_alu_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int N_LANES = 2,
  parameter int ALU_LAT = 1,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_op,
  input  logic [7:0]                   cmd_len,
  input  logic                         opnd_valid,
  output logic                         opnd_ready,
  input  logic [WIDTH*N_LANES-1:0]     opnd_a,
  input  logic [WIDTH*N_LANES-1:0]     opnd_b,
  input  logic [N_LANES-1:0]           opnd_mask,
  output logic [WIDTH*N_LANES-1:0]     alu_a,
  output logic [WIDTH*N_LANES-1:0]     alu_b,
  output logic [2:0]                   alu_select,
  output logic [N_LANES-1:0]           alu_enable,
  input  logic [2*WIDTH*N_LANES-1:0]   alu_result,
  input  logic [N_LANES-1:0]           alu_inf,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [2*WIDTH*N_LANES-1:0]   res_data,
  output logic [N_LANES-1:0]           res_inf,
  output logic                         res_last,
  output logic                         busy,
  output logic                         done
`ifdef VEC_SEQ_INF_COUNT_EN
  , output logic [7:0]                 inf_count
`endif
);
  localparam int RW = 2 * WIDTH * N_LANES;
  localparam int FW = RW + N_LANES + 1;
  localparam int CW = $clog2(DEPTH + 1);
  state_t state;
  logic [7:0] beats_left;
  logic [ALU_LAT:0] trk_v, trk_last;
  logic [N_LANES-1:0] trk_mask [ALU_LAT+1];
  logic [N_LANES-1:0] exit_mask;
  logic [CW-1:0] fifo_count, inflight;
  logic [RW-1:0] lane_data;
  logic [FW-1:0] fifo_out;
  logic cmd_hs, opnd_hs, exit_v;
  always_comb begin
    inflight = '0;
    for (int k = 0; k <= ALU_LAT; k++) inflight += CW'(trk_v[k]);
  end
  assign exit_v     = trk_v[ALU_LAT];
  assign exit_mask  = trk_mask[ALU_LAT];
  assign cmd_ready  = state == IDLE && !rst;
  assign opnd_ready = state == ISSUE && 32'(fifo_count) + 32'(inflight) < DEPTH;
  assign cmd_hs     = cmd_valid && cmd_ready;
  assign opnd_hs    = opnd_valid && opnd_ready;
  assign busy       = state != IDLE;
  assign res_valid  = fifo_count != '0;
  assign {res_data, res_inf, res_last} = fifo_out;
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    assign lane_data[lane_lo(i, 2*WIDTH) +: 2*WIDTH] =
      exit_mask[i] ? alu_result[lane_lo(i, 2*WIDTH) +: 2*WIDTH] : '0;
  end
  vec_res_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (exit_v),
    .pop   (res_valid && res_ready),
    .wdata ({lane_data, alu_inf & exit_mask, trk_last[ALU_LAT]}),
    .rdata (fifo_out),
    .count (fifo_count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beats_left <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_select <= '0;
      alu_enable <= '0;
      trk_v <= '0;
      trk_last <= '0;
      done <= 1'b0;
      for (int k = 0; k <= ALU_LAT; k++) trk_mask[k] <= '0;
    end else begin
      done <= 1'b0;
      alu_enable <= opnd_hs ? opnd_mask : '0;
      trk_v <= {trk_v[ALU_LAT-1:0], opnd_hs};
      trk_last <= {trk_last[ALU_LAT-1:0], opnd_hs && beats_left == 8'd1};
      trk_mask[0] <= opnd_mask;
      for (int k = 1; k <= ALU_LAT; k++) trk_mask[k] <= trk_mask[k-1];
      if (opnd_hs) begin
        alu_a <= opnd_a;
        alu_b <= opnd_b;
        beats_left <= beats_left - 8'd1;
      end
      case (state)
        IDLE: if (cmd_hs) begin
          alu_select <= cmd_op;
          beats_left <= cmd_len;
          state <= cmd_len == 8'd0 ? DONE : ISSUE;
          done <= cmd_len == 8'd0;
        end
        ISSUE: if (opnd_hs && beats_left == 8'd1) state <= DRAIN;
        // leave as the last-tagged beat is written so done lands one cycle after it
        DRAIN: if (inflight == CW'(exit_v)) begin
          state <= DONE;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef VEC_SEQ_INF_COUNT_EN
  logic [8:0] inf_sum;
  always_comb begin
    inf_sum = {1'b0, inf_count};
    for (int k = 0; k < N_LANES; k++) inf_sum += 9'(exit_v && exit_mask[k] && alu_inf[k]);
  end
  always_ff @(posedge clk)
    inf_count <= (rst || cmd_hs) ? '0 : inf_sum > 9'd255 ? 8'd255 : inf_sum[7:0];
`endif
endmodule

// File: tb/tb_vec_alu_sequencer.sv
// tb_vec_alu_sequencer: randomized scoreboard bench with a behavioural ALU responder.
module tb_vec_alu_sequencer;
  import vec_alu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_len = '0;
  logic opnd_valid = 1'b0, opnd_ready;
  logic [7:0] opnd_a = '0, opnd_b = '0;
  logic [1:0] opnd_mask = '0;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_select;
  logic [1:0] alu_enable;
  logic [15:0] alu_result = '0;
  logic [1:0] alu_inf = '0;
  logic res_valid, res_ready = 1'b1;
  logic [15:0] res_data;
  logic [1:0] res_inf;
  logic res_last, busy, done;

  vec_alu_sequencer #(.WIDTH(4), .N_LANES(2), .ALU_LAT(1), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .opnd_valid(opnd_valid), .opnd_ready(opnd_ready), .opnd_a(opnd_a),
    .opnd_b(opnd_b), .opnd_mask(opnd_mask), .alu_a(alu_a), .alu_b(alu_b),
    .alu_select(alu_select), .alu_enable(alu_enable), .alu_result(alu_result),
    .alu_inf(alu_inf), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_inf(res_inf), .res_last(res_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  inf;
    logic        last;
    int          idx;
  } exp_t;
  exp_t q[$];

  int cyc = 0, n_chk = 0, n_pass = 0;
  int cur_len = 0, beats_sent = 0, exp_done_cyc = -1, rdy_cnt = 0;
  int first_hs_cyc = 0, last_hs_cyc = 0, first_res_cyc = 0, last_res_cyc = 0, done_cnt = 0;
  int rr_mode = 1;
  logic [2:0] cur_op = '0;
  logic hs_prev = 1'b0;
  logic [1:0] mask_prev = '0;
  logic [7:0] a_prev = '0, b_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_f(logic [2:0] op, logic [3:0] a, logic [3:0] b);
    case (op)
      OP_ADD:  return 8'(a) + 8'(b);
      OP_SUB:  return 8'(a) - 8'(b);
      OP_MUL:  return 8'(a) * 8'(b);
      OP_AND:  return {4'h0, a & b};
      OP_OR:   return {4'h0, a | b};
      OP_XOR:  return {4'h0, a ^ b};
      default: return {a, b};
    endcase
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ALU responder: one-cycle latency; disabled lanes return junk so masking is observable
  logic [7:0] alu_r;
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      alu_r = alu_f(alu_select, alu_a[i*4 +: 4], alu_b[i*4 +: 4]);
      alu_result[i*8 +: 8] <= alu_enable[i] ? alu_r : 8'hA5;
      alu_inf[i] <= alu_enable[i] ? alu_r[7] : 1'b1;
    end

  always @(posedge clk) begin
    #1;
    res_ready = rr_mode == 0 ? 1'b0 : rr_mode == 1 ? 1'b1 : 1'($urandom_range(1));
  end

  // handshake recorder: issues expectations into the scoreboard and checks ALU drive
  exp_t e_in;
  logic [7:0] r_in;
  always @(negedge clk) begin
    if (rst) begin
      hs_prev = 1'b0;
      q.delete();
      exp_done_cyc = -1;
    end else begin
      chk(alu_enable === (hs_prev ? mask_prev : 2'b00), "alu_enable", 32'(alu_enable), 32'(hs_prev ? mask_prev : 2'b00));
      if (hs_prev) begin
        chk({alu_a, alu_b} === {a_prev, b_prev}, "alu_operands", {16'h0, alu_a, alu_b}, {16'h0, a_prev, b_prev});
        chk(alu_select === cur_op, "alu_select", 32'(alu_select), 32'(cur_op));
      end
      hs_prev = 1'b0;
      if (opnd_ready) rdy_cnt++;
      if (cmd_valid && cmd_ready) begin
        cur_op = cmd_op;
        cur_len = int'(cmd_len);
        beats_sent = 0;
        if (cmd_len == 8'd0) exp_done_cyc = cyc + 1;
      end
      if (opnd_valid && opnd_ready) begin
        for (int i = 0; i < 2; i++) begin
          r_in = alu_f(cur_op, opnd_a[i*4 +: 4], opnd_b[i*4 +: 4]);
          e_in.data[i*8 +: 8] = opnd_mask[i] ? r_in : 8'h00;
          e_in.inf[i] = opnd_mask[i] & r_in[7];
        end
        e_in.last = beats_sent == cur_len - 1;
        e_in.idx = beats_sent;
        q.push_back(e_in);
        if (beats_sent == 0) first_hs_cyc = cyc;
        if (e_in.last) begin
          last_hs_cyc = cyc;
          exp_done_cyc = cyc + 3;
        end
        beats_sent++;
        hs_prev = 1'b1;
        mask_prev = opnd_mask;
        a_prev = opnd_a;
        b_prev = opnd_b;
      end
    end
  end

  exp_t e_out;
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && res_ready) begin
        if (q.size() == 0) chk(1'b0, "unexpected_result", {13'h0, res_data, res_inf, res_last}, 32'h0);
        else begin
          e_out = q.pop_front();
          chk({res_data, res_inf, res_last} === {e_out.data, e_out.inf, e_out.last}, "result",
              {13'h0, res_data, res_inf, res_last}, {13'h0, e_out.data, e_out.inf, e_out.last});
          if (e_out.idx == 0) first_res_cyc = cyc;
          if (e_out.last) last_res_cyc = cyc;
        end
      end
      if (done) begin
        chk(cyc == exp_done_cyc, "done_cycle", 32'(cyc), 32'(exp_done_cyc));
        done_cnt++;
      end
    end
  end

  task automatic issue_cmd(input logic [2:0] op, input logic [7:0] len);
    int g = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_len = len;
    @(negedge clk);
    while (!cmd_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk(1'b0, "cmd_timeout", 32'(g), 32'd200);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input int n, input int gap, input int mask_mode, input bit fixed,
                            input logic [7:0] fa, input logic [7:0] fb);
    for (int k = 0; k < n; k++) begin
      int g = 0;
      while (gap > 0 && $urandom_range(99) < gap) begin
        opnd_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      opnd_valid = 1'b1;
      opnd_a = fixed ? fa : 8'($urandom);
      opnd_b = fixed ? fb : 8'($urandom);
      opnd_mask = mask_mode < 4 ? 2'(mask_mode) : 2'($urandom);
      @(negedge clk);
      while (!opnd_ready && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (g >= 200) chk(1'b0, "opnd_timeout", 32'(g), 32'd200);
      @(posedge clk);
      #1;
    end
    opnd_valid = 1'b0;
  endtask

  task automatic wait_done(input int snap);
    int g = 0;
    while (done_cnt == snap && g < 300) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk(done_cnt != snap, "done_timeout", 32'(done_cnt), 32'(snap + 1));
  endtask

  task automatic drain_q();
    int g = 0;
    while (q.size() != 0 && g < 300) begin
      @(posedge clk);
      g++;
    end
    #1;
  endtask

  initial begin
    int snap, rsnap;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(cmd_ready === 1'b0, "rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk({opnd_ready, res_valid, busy, done} === 4'b0, "rst_flags", {28'h0, opnd_ready, res_valid, busy, done}, 32'h0);
    chk({alu_a, alu_b, alu_select, alu_enable} === '0, "rst_alu", {11'h0, alu_a, alu_b, alu_select, alu_enable}, 32'h0);
    chk({res_data, res_inf, res_last} === '0, "rst_res", {13'h0, res_data, res_inf, res_last}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk(cmd_ready === 1'b1, "post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;

    snap = done_cnt;
    issue_cmd(OP_ADD, 8'd1);
    send_beats(1, 0, 3, 1'b1, 8'h35, 8'h12);
    wait_done(snap);
    chk(first_res_cyc - first_hs_cyc == 3, "latency", 32'(first_res_cyc - first_hs_cyc), 32'd3);

    snap = done_cnt;
    issue_cmd(OP_MUL, 8'd8);
    send_beats(8, 0, 3, 1'b0, 8'h0, 8'h0);
    wait_done(snap);
    drain_q();
    chk(last_hs_cyc - first_hs_cyc == 7, "issue_streak", 32'(last_hs_cyc - first_hs_cyc), 32'd7);
    chk(last_res_cyc - first_res_cyc == 7, "result_streak", 32'(last_res_cyc - first_res_cyc), 32'd7);

    rr_mode = 0;
    @(posedge clk);
    #1;
    snap = done_cnt;
    issue_cmd(OP_SUB, 8'd8);
    fork
      send_beats(8, 0, 3, 1'b0, 8'h0, 8'h0);
      begin
        repeat (12) @(posedge clk);
        #2;
        chk(beats_sent == 4, "backpressure_beats", 32'(beats_sent), 32'd4);
        chk(opnd_ready === 1'b0, "backpressure_ready", 32'(opnd_ready), 32'd0);
        rr_mode = 1;
      end
    join
    wait_done(snap);
    drain_q();
    chk(q.size() == 0, "backpressure_drained", 32'(q.size()), 32'd0);

    snap = done_cnt;
    issue_cmd(OP_ADD, 8'd2);
    send_beats(2, 0, 1, 1'b1, 8'hF7, 8'h9C);
    wait_done(snap);
    drain_q();

    snap = done_cnt;
    rsnap = rdy_cnt;
    issue_cmd(OP_MUL, 8'd0);
    wait_done(snap);
    repeat (4) @(posedge clk);
    #1;
    chk(rdy_cnt == rsnap, "len0_no_opnd_ready", 32'(rdy_cnt), 32'(rsnap));
    chk(res_valid === 1'b0, "len0_no_result", 32'(res_valid), 32'd0);

    issue_cmd(OP_XOR, 8'd8);
    send_beats(3, 0, 3, 1'b0, 8'h0, 8'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk({busy, res_valid, cmd_ready} === 3'b001, "midrst_state", {29'h0, busy, res_valid, cmd_ready}, 32'h1);
    @(posedge clk);
    #1;
    snap = done_cnt;
    issue_cmd(OP_OR, 8'd1);
    send_beats(1, 0, 3, 1'b0, 8'h0, 8'h0);
    wait_done(snap);
    drain_q();
    chk(q.size() == 0, "midrst_clean", 32'(q.size()), 32'd0);

    rr_mode = 2;
    for (int c = 0; c < 20; c++) begin
      snap = done_cnt;
      issue_cmd(3'($urandom_range(7)), 8'($urandom_range(10, 1)));
      send_beats(int'(cmd_len), 30, 4, 1'b0, 8'h0, 8'h0);
      wait_done(snap);
    end
    rr_mode = 1;
    drain_q();
    chk(q.size() == 0, "final_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
